// File: rtl/pi_control_system.sv
// Discrete PI controller on IEEE-754 single floats, sequenced through fixed-latency add/mul stages.
// Define PI_ANTIWINDUP_EN to compile in the integrator clamp state (adds one cycle of latency).
module pi_control_system #(
  parameter logic [31:0] KP         = 32'h3f800000,
  parameter logic [31:0] KI_TS      = 32'h3c23d70a,
  parameter logic [31:0] INIT_INTEG = 32'h00000000,
  parameter logic [31:0] INTEG_MAX  = 32'h3f800000,
  parameter logic [31:0] INTEG_MIN  = 32'hbf800000,
  parameter int unsigned ADD_LAT    = 7,
  parameter int unsigned MUL_LAT    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sta,
  input  logic [31:0] ref_val,
  input  logic [31:0] fb,
  output logic [31:0] u,
  output logic        done_sig,
  output logic        busy
);

  localparam logic [7:0] AddLoad = 8'(ADD_LAT - 1);
  localparam logic [7:0] MulLoad = 8'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    StIdle, StSub, StMul, StInt, StSum, StDone
`ifdef PI_ANTIWINDUP_EN
    , StClamp
`endif
  } state_e;

  // Round-to-nearest-even adder; denormals flush to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  dexp;
    logic [26:0] mx, my, mask;
    logic [27:0] s;
    logic [24:0] m;
    logic        rnd;
    int          e;
    if (b[30:0] > a[30:0]) begin x = b; y = a; end
    else begin x = a; y = b; end
    mx = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
    my = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
    dexp = x[30:23] - y[30:23];
    if (dexp >= 8'd27) begin
      my = {26'd0, |my};
    end else begin
      mask = (27'd1 << dexp) - 27'd1;
      my = (my >> dexp) | {26'd0, |(my & mask)};
    end
    e = int'(x[30:23]);
    if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
    else s = {1'b0, mx} - {1'b0, my};
    if (s == 28'd0) return 32'd0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!s[26]) begin
        s = s << 1;
        e = e - 1;
      end
    end
    rnd = s[2] & ((|s[1:0]) | s[3]);
    m = {1'b0, s[26:3]} + {24'd0, rnd};
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e <= 0) return {x[31], 31'd0};
    if (e >= 255) return {x[31], 8'hff, 23'd0};
    return {x[31], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] prod;
    logic [24:0] m;
    logic        g, st, sgn;
    int          e;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sgn, 31'd0};
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      m = {1'b0, prod[47:24]}; g = prod[23]; st = |prod[22:0]; e = e + 1;
    end else begin
      m = {1'b0, prod[46:23]}; g = prod[22]; st = |prod[21:0];
    end
    m = m + {24'd0, g & (st | m[0])};
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e <= 0) return {sgn, 31'd0};
    if (e >= 255) return {sgn, 8'hff, 23'd0};
    return {sgn, e[7:0], m[22:0]};
  endfunction

`ifdef PI_ANTIWINDUP_EN
  // Maps float bits onto an unsigned key whose order matches numeric order.
  function automatic logic [31:0] ord_key(input logic [31:0] v);
    return v[31] ? ~v : {1'b1, v[30:0]};
  endfunction
`else
  logic unused_bounds;
  assign unused_bounds = ^{INTEG_MAX, INTEG_MIN};
`endif

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d, busy_q, busy_d;
  logic [31:0] ref_q, fb_q, e_q, p_q, k_q, integ_n_q, un_q, integ_q, u_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
    unique case (state_q)
      StIdle: if (sta) begin state_d = StSub; cnt_d = AddLoad; end
      StSub:  if (cnt_q == 8'd0) begin state_d = StMul; cnt_d = MulLoad; end
      StMul:  if (cnt_q == 8'd0) begin state_d = StInt; cnt_d = AddLoad; end
`ifdef PI_ANTIWINDUP_EN
      StInt:   if (cnt_q == 8'd0) begin state_d = StClamp; cnt_d = 8'd0; end
      StClamp: begin state_d = StSum; cnt_d = AddLoad; end
`else
      StInt:  if (cnt_q == 8'd0) begin state_d = StSum; cnt_d = AddLoad; end
`endif
      StSum:  if (cnt_q == 8'd0) begin state_d = StDone; cnt_d = 8'd0; end
      StDone: state_d = StIdle;
      default: begin state_d = StIdle; cnt_d = 8'd0; end
    endcase
  end

  // busy stays high through the done cycle even though the FSM is already back in idle
  always_comb begin
    done_d = (state_q == StDone);
    busy_d = (state_d != StIdle) || (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_q     <= 32'd0;
      fb_q      <= 32'd0;
      e_q       <= 32'd0;
      p_q       <= 32'd0;
      k_q       <= 32'd0;
      integ_n_q <= 32'd0;
      un_q      <= 32'd0;
      integ_q   <= INIT_INTEG;
      u_q       <= 32'd0;
    end else begin
      if (state_q == StIdle && sta) begin
        ref_q <= ref_val;
        fb_q  <= fb;
      end
      if (state_q == StSub && cnt_q == 8'd0) e_q <= fp_add(ref_q, {~fb_q[31], fb_q[30:0]});
      if (state_q == StMul && cnt_q == 8'd0) begin
        p_q <= fp_mul(KP, e_q);
        k_q <= fp_mul(KI_TS, e_q);
      end
      if (state_q == StInt && cnt_q == 8'd0) integ_n_q <= fp_add(integ_q, k_q);
`ifdef PI_ANTIWINDUP_EN
      if (state_q == StClamp) begin
        if (ord_key(integ_n_q) > ord_key(INTEG_MAX)) integ_n_q <= INTEG_MAX;
        else if (ord_key(integ_n_q) < ord_key(INTEG_MIN)) integ_n_q <= INTEG_MIN;
      end
`endif
      if (state_q == StSum && cnt_q == 8'd0) un_q <= fp_add(p_q, integ_n_q);
      if (state_q == StDone) begin
        u_q     <= un_q;
        integ_q <= integ_n_q;
      end
    end
  end

  assign u        = u_q;
  assign done_sig = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pi_control_system.sv
// Randomized self-checking bench for pi_control_system against a real-arithmetic reference model.
module tb_pi_control_system;

  localparam logic [31:0] KP      = 32'h40000000;
  localparam logic [31:0] KI_TS   = 32'h3f000000;
  localparam int unsigned ADD_LAT = 7;
  localparam int unsigned MUL_LAT = 5;
`ifdef PI_ANTIWINDUP_EN
  localparam int          L         = 3 * ADD_LAT + MUL_LAT + 2;
  localparam logic [31:0] EXP_STEP3 = 32'h40400000;
  localparam logic [31:0] EXP_NEG   = 32'hc0400000;
`else
  localparam int          L         = 3 * ADD_LAT + MUL_LAT + 1;
  localparam logic [31:0] EXP_STEP3 = 32'h40600000;
  localparam logic [31:0] EXP_NEG   = 32'hc0600000;
`endif

  logic        clk = 1'b0, rst = 1'b0, sta = 1'b0;
  logic [31:0] ref_val = 32'd0, fb = 32'd0, u;
  logic        done_sig, busy;

  int          n_pass = 0, n_checks = 0, done_cnt = 0, exp_done = 0;
  logic [31:0] integ_m = 32'd0;
  logic [31:0] got;

  pi_control_system #(
    .KP(KP), .KI_TS(KI_TS), .INIT_INTEG(32'h00000000),
    .INTEG_MAX(32'h3f800000), .INTEG_MIN(32'hbf800000),
    .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst(rst), .sta(sta), .ref_val(ref_val), .fb(fb),
    .u(u), .done_sig(done_sig), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done_sig) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, req);
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Round a double to the nearest-even single (results stay in normal range here).
  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    logic [24:0] m;
    int          e;
    d = $realtobits(x);
    if (x == 0.0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    m = {2'b01, d[51:29]};
    if (d[28] && (d[27:0] != 28'd0 || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] r, input logic [31:0] f);
    logic [31:0] e, p, k, in;
    e  = r2f(f2r(r) - f2r(f));
    p  = r2f(f2r(KP) * f2r(e));
    k  = r2f(f2r(KI_TS) * f2r(e));
    in = r2f(f2r(integ_m) + f2r(k));
`ifdef PI_ANTIWINDUP_EN
    if (f2r(in) > 1.0) in = 32'h3f800000;
    else if (f2r(in) < -1.0) in = 32'hbf800000;
`endif
    integ_m = in;
    return r2f(f2r(p) + f2r(in));
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    integ_m = 32'd0;
  endtask

  // Starts a transaction; optional extra sta pulses and a mid-run reset at cycle rst_at.
  task automatic run(input logic [31:0] r, input logic [31:0] f, input bit extra,
                     input int rst_at, output logic [31:0] res, output int lat);
    bit busy_ok = 1'b1;
    ref_val = r; fb = f; sta = 1'b1;
    @(posedge clk); #1;
    sta = 1'b0;
    lat = -1;
    res = u;
    for (int c = 1; c <= L + 4; c++) begin
      @(posedge clk); #1;
      if (rst_at != 0 && c == rst_at) begin
        check_eq("rst_u", u, 32'd0);
        check_eq("rst_done", {31'd0, done_sig}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        integ_m = 32'd0;
        return;
      end
      busy_ok &= busy;
      if (done_sig) begin
        lat = c;
        res = u;
        break;
      end
      if (c == 1) begin ref_val = $urandom; fb = $urandom; end
      sta = extra && (c == 2 || c == 9);
      if (rst_at != 0 && c == rst_at - 1) rst = 1'b0;
    end
    sta = 1'b0;
    check_eq("busy_span", {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic [31:0] r, input logic [31:0] f,
                     input bit extra, input int gap, output logic [31:0] res);
    logic [31:0] exp_u;
    int          lat;
    exp_u = model_step(r, f);
    run(r, f, extra, 0, res, lat);
    exp_done++;
    check_eq({tag, "_lat"}, 32'(lat), 32'(L));
    check_eq({tag, "_u"}, res, exp_u);
    if (gap > 0) begin
      @(posedge clk); #1;
      check_eq({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_done_low"}, {31'd0, done_sig}, 32'd0);
      check_eq({tag, "_u_hold"}, u, res);
      repeat (gap - 1) begin @(posedge clk); #1; end
    end
  endtask

  function automatic logic [31:0] rand_val();
    return r2f(real'(int'($urandom_range(20000)) - 10000) / 100.0);
  endfunction

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_u", u, 32'd0);
    check_eq("reset_done", {31'd0, done_sig}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    txn("step1", 32'h3f800000, 32'h0, 1'b0, 1, got);
    check_eq("step1_const", got, 32'h40200000);
    txn("step2", 32'h3f800000, 32'h0, 1'b0, 1, got);
    check_eq("step2_const", got, 32'h40400000);
    txn("zero_err", 32'h40a00000, 32'h40a00000, 1'b0, 1, got);
    check_eq("zero_err_const", got, 32'h3f800000);
    txn("step3", 32'h3f800000, 32'h0, 1'b0, 1, got);
    check_eq("step3_const", got, EXP_STEP3);
    for (int i = 0; i < 6; i++) txn("neg", 32'h0, 32'h3f800000, 1'b0, 1, got);
    check_eq("neg_const", got, EXP_NEG);

    do_reset();
    txn("ignored_sta", 32'h3f800000, 32'h0, 1'b1, L + 4, got);
    check_eq("ignored_sta_const", got, 32'h40200000);

    run(32'h3f800000, 32'h0, 1'b0, 12, got, lat);
    txn("post_rst", 32'h3f800000, 32'h0, 1'b0, 1, got);
    check_eq("post_rst_const", got, 32'h40200000);

    for (int i = 0; i < 24; i++) begin
      txn("rand", rand_val(), rand_val(), 1'b0, int'($urandom_range(2)), got);
    end

    repeat (4) @(posedge clk);
    #1;
    check_eq("done_count", 32'(done_cnt), 32'(exp_done));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
